// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, then ack.
// Optional macro PS2_TX_ACK_CHECK_EN turns a nack at the ack clock into tx_error.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1400,
    parameter int TIMEOUT_CYCLES = 210000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_CLK_I,
    input  logic       PS2_DAT_I,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

    logic [1:0]       clk_sync_reg, dat_sync_reg;
    logic             clk_filt_reg, fall_reg;
    logic [FLT_W-1:0] flt_cnt_reg;

    state_t           state_reg, state_next;
    logic [7:0]       data_reg, data_next;
    logic             parity_reg, parity_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       idx_reg, idx_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             dat_oe_reg, dat_oe_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic             timeout_hit;

    // Synchronizers idle high so reset never manufactures a falling edge.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            clk_sync_reg <= 2'b11;
            dat_sync_reg <= 2'b11;
            clk_filt_reg <= 1'b1;
            flt_cnt_reg  <= '0;
            fall_reg     <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[0], PS2_CLK_I};
            dat_sync_reg <= {dat_sync_reg[0], PS2_DAT_I};
            fall_reg     <= 1'b0;
            if (clk_sync_reg[1] == clk_filt_reg) begin
                flt_cnt_reg <= '0;
            end else if (flt_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt_reg <= clk_sync_reg[1];
                flt_cnt_reg  <= '0;
                fall_reg     <= clk_filt_reg;
            end else begin
                flt_cnt_reg <= flt_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_reg  <= IDLE;
            data_reg   <= '0;
            parity_reg <= 1'b0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            clk_oe_reg <= 1'b0;
            dat_oe_reg <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            parity_reg <= parity_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            clk_oe_reg <= clk_oe_next;
            dat_oe_reg <= dat_oe_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        parity_next = parity_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        clk_oe_next = clk_oe_reg;
        dat_oe_next = dat_oe_reg;
        done_next   = 1'b0;
        error_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                if (tx_start) begin
                    data_next   = tx_data;
                    parity_next = ~^tx_data;
                    cnt_next    = '0;
                    clk_oe_next = 1'b1;
                    state_next  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes out one cycle before the clock line is released.
                if (dat_oe_reg) begin
                    clk_oe_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = REQ;
                end else if (cnt_reg == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    dat_oe_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            REQ, BITS, ACK, WAIT_IDLE: begin
                if (timeout_hit) begin
                    clk_oe_next = 1'b0;
                    dat_oe_next = 1'b0;
                    error_next  = 1'b1;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    case (state_reg)
                        REQ: if (fall_reg) begin
                            dat_oe_next = ~data_reg[0];
                            idx_next    = 4'd1;
                            state_next  = BITS;
                        end
                        BITS: if (fall_reg) begin
                            if (idx_reg < 4'd8) begin
                                dat_oe_next = ~data_reg[idx_reg[2:0]];
                                idx_next    = idx_reg + 4'd1;
                            end else if (idx_reg == 4'd8) begin
                                dat_oe_next = ~parity_reg;
                                idx_next    = 4'd9;
                            end else begin
                                dat_oe_next = 1'b0;
                                state_next  = ACK;
                            end
                        end
                        ACK: if (fall_reg) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            if (dat_sync_reg[1]) begin
                                error_next = 1'b1;
                                cnt_next   = '0;
                                state_next = IDLE;
                            end else begin
                                state_next = WAIT_IDLE;
                            end
`else
                            state_next = WAIT_IDLE;
`endif
                        end
                        WAIT_IDLE: if (clk_filt_reg && dat_sync_reg[1]) begin
                            done_next  = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_busy    = (state_reg != IDLE);
    assign tx_done    = done_reg;
    assign tx_error   = error_reg;
    assign PS2_CLK_OE = clk_oe_reg;
    assign PS2_DAT_OE = dat_oe_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks frames out of the host and checks them against a frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 4000;
    localparam int FLT = 8;
    localparam int H   = 30;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error, clk_oe, dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_i, ps2_dat_i;

    assign ps2_clk_i = dev_clk & ~clk_oe;
    assign ps2_dat_i = dev_dat & ~dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
        .CLK(clk), .nRESET(nrst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .PS2_CLK_I(ps2_clk_i), .PS2_DAT_I(ps2_dat_i),
        .PS2_CLK_OE(clk_oe), .PS2_DAT_OE(dat_oe)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, err_cnt = 0, bad_pulse = 0;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if ((tx_done && tx_error) || ((tx_done || tx_error) && tx_busy)) bad_pulse++;
    end

    // Expected line levels as seen by the device: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, samples on rising edges, optionally acks.
    task automatic dev_run(input int nclk, input bit ack, input bit glitch,
                           output logic [10:0] got, output bit seen);
        int t = 0;
        got  = '1;
        seen = 1'b0;
        while (!(ps2_clk_i === 1'b1 && ps2_dat_i === 1'b0) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10000) return;
        seen = 1'b1;
        tick(H);
        got[0] = ps2_dat_i;
        for (int k = 1; k <= 10 && k <= nclk; k++) begin
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            got[k] = ps2_dat_i;
            if (glitch && k == 4) begin
                tick(H / 2);
                dev_clk = 1'b0;
                tick(3);
                dev_clk = 1'b1;
                tick(H - H / 2 - 3);
            end else begin
                tick(H);
            end
        end
        if (nclk >= 11) begin
            dev_dat = ack;
            tick(5);
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            tick(5);
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int t = 0;
        while (tx_busy && t < TMO + 2000) begin
            @(negedge clk);
            t++;
        end
        ok = !tx_busy;
        tick(2);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(3);
        vectors++;
        if ({tx_busy, tx_done, tx_error, clk_oe, dat_oe} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000", {tx_busy, tx_done, tx_error, clk_oe, dat_oe});
        end
        nrst = 1'b1;
        tick(2);
        $display("reset: busy=%b oe=%b%b", tx_busy, clk_oe, dat_oe);
    endtask

    task automatic test_frame(input logic [7:0] d, input bit ack, input bit glitch, input string tag);
        int d0 = done_cnt, e0 = err_cnt;
        int exp_done = (!ack || !ACK_CHK) ? 1 : 0;
        logic [10:0] got, exp;
        bit seen, ok;
        exp = ref_frame(d);
        start_tx(d);
        dev_run(11, ack, glitch, got, seen);
        wait_idle(ok);
        $display("frame %s: data=%h bits=%b done=%0d err=%0d", tag, d, got, done_cnt - d0, err_cnt - e0);
        vectors++;
        if (!seen || got !== exp) begin
            miscompares++;
            $display("FAIL %s_bits: got %b want %b (request seen=%0d)", tag, got, exp, seen);
        end
        vectors++;
        if ((done_cnt - d0) != exp_done || (err_cnt - e0) != 1 - exp_done) begin
            miscompares++;
            $display("FAIL %s_result: got done=%0d err=%0d want done=%0d err=%0d",
                     tag, done_cnt - d0, err_cnt - e0, exp_done, 1 - exp_done);
        end
        vectors++;
        if (!ok || {tx_busy, clk_oe, dat_oe} !== 3'b0) begin
            miscompares++;
            $display("FAIL %s_idle: got busy/oe=%b want 000", tag, {tx_busy, clk_oe, dat_oe});
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        logic [7:0] d = 8'($urandom);
        logic [10:0] got;
        bit seen, ok;
        test_frame(8'($urandom), 1'b0, 1'b0, "b2b_first");
        start_tx(d);
        vectors++;
        if ({tx_busy, clk_oe, dat_oe} !== 3'b110) begin
            miscompares++;
            $display("FAIL b2b_start: got busy/clk_oe/dat_oe=%b want 110", {tx_busy, clk_oe, dat_oe});
        end
        while (clk_oe && !dat_oe && k < INH + 50) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (k != INH || {clk_oe, dat_oe} !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_inhibit: got %0d cycles oe=%b want %0d cycles oe=11", k, {clk_oe, dat_oe}, INH);
        end
        tick(1);
        vectors++;
        if ({clk_oe, dat_oe} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_release: got oe=%b want 01", {clk_oe, dat_oe});
        end
        dev_run(11, 1'b0, 1'b0, got, seen);
        wait_idle(ok);
        $display("back_to_back: data=%h inhibit=%0d bits=%b", d, k, got);
        vectors++;
        if (!ok || got !== ref_frame(d)) begin
            miscompares++;
            $display("FAIL b2b_bits: got %b want %b", got, ref_frame(d));
        end
    endtask

    task automatic test_timeout();
        int k = 0, t = 0;
        int d0;
        start_tx(8'($urandom));
        while (clk_oe && t < INH + 50) begin
            @(negedge clk);
            t++;
        end
        d0 = done_cnt;
        while (!tx_error && k < TMO + 100) begin
            @(negedge clk);
            k++;
        end
        $display("timeout: error after %0d cycles from request", k);
        vectors++;
        if (k != TMO || {tx_busy, clk_oe, dat_oe} !== 3'b0) begin
            miscompares++;
            $display("FAIL timeout_at: got %0d cycles busy/oe=%b want %0d cycles 000", k, {tx_busy, clk_oe, dat_oe}, TMO);
        end
        tick(1);
        vectors++;
        if (tx_error !== 1'b0 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got error=%b done_delta=%0d want 0 0", tx_error, done_cnt - d0);
        end
    endtask

    task automatic test_hold_start();
        int d0 = done_cnt;
        logic [7:0] d = 8'($urandom);
        logic [10:0] got;
        bit seen, ok;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_data = ~d;
        dev_run(11, 1'b0, 1'b0, got, seen);
        tx_start = 1'b0;
        wait_idle(ok);
        tick(50);
        $display("hold_start: data=%h bits=%b done=%0d", d, got, done_cnt - d0);
        vectors++;
        if (got !== ref_frame(d) || done_cnt - d0 != 1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_start: got bits=%b done=%0d busy=%b want bits=%b done=1 busy=0",
                     got, done_cnt - d0, tx_busy, ref_frame(d));
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        bit seen;
        start_tx(8'($urandom));
        dev_run(4, 1'b0, 1'b0, got, seen);
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        $display("reset_mid: busy=%b oe=%b%b", tx_busy, clk_oe, dat_oe);
        vectors++;
        if (!seen || {tx_busy, clk_oe, dat_oe} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy/oe=%b want 000", {tx_busy, clk_oe, dat_oe});
        end
        nrst    = 1'b1;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        tick(20);
    endtask

    initial begin
        test_reset();
        test_frame(8'hED, 1'b0, 1'b0, "ed");
        test_frame(8'h00, 1'b0, 1'b0, "zero");
        test_frame(8'hFF, 1'b0, 1'b0, "ones");
        for (int i = 0; i < 5; i++) test_frame(8'($urandom), 1'b0, 1'b0, "random");
        test_back_to_back();
        test_hold_start();
        test_timeout();
        test_frame(8'($urandom), 1'b1, 1'b0, "nack");
        test_frame(8'($urandom), 1'b0, 1'b1, "glitch");
        test_reset_mid();
        test_frame(8'($urandom), 1'b0, 1'b0, "after_reset");
        vectors++;
        if (bad_pulse != 0) begin
            miscompares++;
            $display("FAIL pulse_rules: got %0d bad pulses want 0", bad_pulse);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- Host-to-device PS/2 transmitter.
- Sends one command byte (LED set, typematic, reset, etc.) from the Spectrum core to the attached PS/2 keyboard.
- Covers the direction the existing keyboard receiver does not.
- Sits beside the keyboard receiver on the shared PS2_CLK/PS2_DAT pins and drives them open-drain through output enables; the top level arbitrates so the receiver ignores frames while tx_busy=1.

## Interface
- INHIBIT_CYCLES, default 1400: cycles the clock line is held low before the request (100 µs at 14 MHz).
- TIMEOUT_CYCLES, default 210000: maximum cycles from request to completion (15 ms at 14 MHz).
- FILTER_LEN, default 8: consecutive equal samples required to accept a new PS2_CLK level.

Ports:
- CLK  in  1  system clock, 14 MHz (clk_ula).
- nRESET  in  1  reset; synchronous and active-low.
- tx_data  in  8  command byte.
- tx_start  in  1  one-cycle request; sampled only in IDLE.
- tx_busy  out  1  high from the cycle after tx_start until return to IDLE.
- tx_done  out  1  one-cycle pulse on successful completion.
- tx_error  out  1  one-cycle pulse on timeout or missing ack.
- PS2_CLK_I  in  1  raw clock pin level (asynchronous).
- PS2_DAT_I  in  1  raw data pin level (asynchronous).
- PS2_CLK_OE  out  1  1 = drive clock low.
- PS2_DAT_OE  out  1  1 = drive data low.

## Operation
- PS2_CLK_I and PS2_DAT_I each pass through a 2-FF synchronizer.
- Clock then passes a FILTER_LEN glitch filter. A falling edge event (fall) is filtered clock going 1→0.
- Frame: tx_data LSB first, then odd parity (~^tx_data), then stop (line released).
- States:
  - IDLE: OEs 0. tx_start=1 latches tx_data, computes parity, loads inhibit counter, goes to INHIBIT.
  - INHIBIT: CLK_OE=1. When the counter reaches INHIBIT_CYCLES, set DAT_OE=1 (start bit), then on the next cycle set CLK_OE=0 and go to REQ. The timeout counter starts at REQ entry.
  - REQ: wait for fall, which goes to BITS with bit index 0. On that fall, DAT_OE=~tx_data[0].
  - BITS: each fall advances the index. Falls 2–8 drive data bits 1–7. Fall 9 drives ~parity. Fall 10 sets DAT_OE=0 (stop) and goes to ACK.
  - ACK: on fall 11, sample synchronized data. Data 0 = ack OK, go to WAIT_IDLE; data 1 = nack.
  - WAIT_IDLE: wait until filtered clock=1 and data=1, then pulse tx_done and go to IDLE.
- Data is changed only on fall events, never at other times.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in REQ/BITS/ACK/WAIT_IDLE:
  - OEs go to 0 in the same cycle;
  - tx_error pulses;
  - state goes to IDLE.
- tx_start while busy is ignored; there is no queue.

## Timing
- Reset values: tx_busy=0, tx_done=0, tx_error=0, PS2_CLK_OE=0, PS2_DAT_OE=0; state IDLE; all counters 0.
- Reset mid-frame releases both lines on the next CLK edge.
- tx_start at cycle N:
  - tx_busy=1 and CLK_OE=1 at N+1;
  - DAT_OE=1 at N+1+INHIBIT_CYCLES;
  - CLK_OE=0 one cycle later.
- Fall-to-DAT_OE latency is 2 (sync) + FILTER_LEN + 1 cycles. This is well inside the ≥30 µs device clock-low half period.
- tx_done or tx_error pulses in the same cycle tx_busy drops. They are mutually exclusive.
- Fall arriving in the same cycle as timeout: timeout wins.
- Counters saturate; no wrap-around.

## Configuration
- PS2_TX_ACK_CHECK_EN defined:
  - ACK state samples data at fall 11;
  - nack (data=1) releases the lines, pulses tx_error and returns to IDLE without tx_done.
- PS2_TX_ACK_CHECK_EN undefined:
  - fall 11 always goes to WAIT_IDLE;
  - the ack level is ignored;
  - only timeout produces tx_error.

## Test plan
- Device model clocking at 12.5 kHz, tx_data=8'hED: bits sampled on rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1. Ack 0 → tx_done pulse, tx_busy 0, OEs 0.
- tx_data=8'h00: parity bit 1. tx_data=8'hFF: parity bit 0.
- tx_start held during a frame: no second frame. Pulse after tx_done: INHIBIT restarts, CLK_OE=1 for exactly INHIBIT_CYCLES cycles.
- Device never clocks: tx_error at REQ entry + TIMEOUT_CYCLES, OEs 0, tx_done never pulses.
- Ack=1 at fall 11: with PS2_TX_ACK_CHECK_EN, tx_error and no tx_done. Without it, tx_done.
- 3-cycle glitch on PS2_CLK_I (FILTER_LEN=8): no bit advance. nRESET low mid-BITS: OEs 0 and tx_busy 0 next cycle.
